bsr_mem_arb: RTL and testbench
==============================

Name: bsr_mem_arb

Overview:
- Two-port arbiter sharing one 256-bit block memory port between the instruction-cache tile (port I) and the data-cache tile (port D).
- Sits between both cache tiles and the memory/bus interface; uses the same OPM/OK protocol on every side.
- Holds a grant for a whole transaction, rotates priority between the ports, and returns a fault if memory stalls too long.

Parameters:
- TMO_CYC, 1023: memory-side HOLD cycles allowed before the granted port gets FAULT; 0 disables the timeout.
- CNT_W, 10: width of the timeout counter; must satisfy TMO_CYC < 2^CNT_W.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- iReqAddr  in  20  port I block address.
- iReqOpm  in  5  port I OPM {WR,OE,Z0,S1,S0}.
- iReqDataO  in  256  port I write data.
- iReqDataI  out  256  port I read data.
- iReqOK  out  2  port I OK status.
- dReqAddr  in  20  port D block address.
- dReqOpm  in  5  port D OPM.
- dReqDataO  in  256  port D write data.
- dReqDataI  out  256  port D read data.
- dReqOK  out  2  port D OK status.
- memAddr  out  20  memory address.
- memOpm  out  5  memory OPM.
- memDataO  out  256  memory write data.
- memDataI  in  256  memory read data.
- memOK  in  2  memory OK status.
- arbFault  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- OK encoding: READY=2'b00, OK=2'b01, HOLD=2'b10, FAULT=2'b11.
- A port is "active" when Opm[4:3] != 0.
- State register values: IDLE, GNT_I, GNT_D, DRAIN.
- Reset values:
  - state=IDLE, rrLast=I (so D wins the first tie), tmoCnt=0, arbFault=0.
  - memOpm=5'b00000, memAddr=0, memDataO=0.
  - iReqOK=dReqOK=READY; both ReqDataI=0.
- IDLE:
  - memOpm=00000.
  - Any active port sees HOLD; an inactive port sees READY.
  - Next state: only D active -> GNT_D; only I active -> GNT_I.
  - Both active -> grant the port that is not rrLast, and rrLast <= granted port.
  - A grant is registered, so the request reaches memory one cycle after the grant (2 cycles after the requester first asserts Opm).
- GNT_x (x = granted port):
  - memAddr, memOpm and memDataO are registered copies of port x's inputs, updated every cycle.
  - Port x: xReqOK = memOK and xReqDataI = memDataI, combinational pass-through.
  - Other port: HOLD if active, READY if not; its ReqDataI holds its last value.
  - Port x goes inactive (Opm[4:3]==0) -> DRAIN, memOpm <= 00000.
  - Port x may change Opm/Addr while still active (the dirty-writeback -> refill sequence); the grant is kept and the new request is forwarded the next cycle.
- DRAIN:
  - memOpm=00000; both active ports see HOLD.
  - Waits until memOK != OK, i.e. memory has seen the drop, then -> IDLE.
  - This enforces at least one idle memory cycle between owners.
- Timeout:
  - tmoCnt increments in GNT_x while memOK==HOLD and clears on any other memOK value.
  - When tmoCnt reaches TMO_CYC: xReqOK=FAULT for exactly one cycle, arbFault<=1, memOpm<=00000, -> DRAIN.
  - Port x must drop Opm after seeing FAULT. If it stays active after DRAIN, it is re-arbitrated normally.
- Simultaneous events:
  - The granted port going inactive in the same cycle as the timeout: treat as a normal release; no FAULT.
  - The other port asserting in that cycle waits for IDLE.
- Reset asserted mid-transaction: return to reset values next edge and abandon the in-flight request. Memory sees Opm=00000 and no FAULT is reported.
- Widths: addr and data are passed through unchanged; no byte lanes are interpreted.

Test Plan:
- Single I read: iReqOpm=01111 addr=0x12340, memOK=OK after 3 HOLD cycles -> memAddr=0x12340 two cycles after assert; iReqOK sequence HOLD,HOLD,...,OK; iReqDataI=memDataI; dReqOK=READY throughout.
- Simultaneous request from reset: both assert 01111 -> D granted first and I sees HOLD; after D drops, DRAIN, then I granted. Repeat the collision -> I granted first (rotation).
- D writeback then refill: dReqOpm=10111 to OK, then 01111 at a new address without dropping -> grant held; memOpm shows 10111 then 01111; I blocked with HOLD the whole time.
- Timeout: TMO_CYC=8, memOK stuck at HOLD -> dReqOK=FAULT on the 8th HOLD cycle; arbFault=1; memOpm=00000 next cycle; I served afterwards.
- Reset mid-grant: assert reset during GNT_I -> next cycle memOpm=00000, iReqOK=READY, state IDLE, arbFault=0.
- Idle ports: both Opm=00000 for 20 cycles -> memOpm=00000, both OK outputs READY, no state change.

Source files
------------

// File: rtl/bsr_mem_arb.sv
// ---------------------------------------------------------------------------
// bsr_mem_arb
//
// Two-port arbiter that shares one 256-bit block memory port between the
// instruction-cache tile (port I) and the data-cache tile (port D). All sides
// use the OPM/OK handshake:
//   OPM {WR,OE,Z0,S1,S0}: a port is active while OPM[4:3] != 0.
//   OK  READY=00, OK=01, HOLD=10, FAULT=11.
//
// A grant lasts for a whole transaction, which may span several requests
// (e.g. dirty writeback followed by refill) as long as the owner stays active.
// Priority between the two ports rotates on collisions. If memory answers
// HOLD for TMO_CYC consecutive cycles, the owner is given FAULT for one
// cycle, the request is withdrawn from memory and a sticky fault flag is set.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   iReqAddr/Opm/DataO      port I request (block address, OPM, write data)
//   iReqDataI/OK            port I response (read data, OK status)
//   dReqAddr/Opm/DataO      port D request
//   dReqDataI/OK            port D response
//   memAddr/Opm/DataO       registered request towards memory
//   memDataI/OK             memory response
//   arbFault                sticky timeout flag, cleared only by reset
//
// Parameters:
//   TMO_CYC  HOLD cycles allowed before FAULT; 0 disables the timeout.
//   CNT_W    timeout counter width; TMO_CYC must be < 2**CNT_W.
// ---------------------------------------------------------------------------
module bsr_mem_arb #(
  parameter int TMO_CYC = 1023,
  parameter int CNT_W   = 10
) (
  input  logic         clock,
  input  logic         reset,

  input  logic [19:0]  iReqAddr,
  input  logic [4:0]   iReqOpm,
  input  logic [255:0] iReqDataO,
  output logic [255:0] iReqDataI,
  output logic [1:0]   iReqOK,

  input  logic [19:0]  dReqAddr,
  input  logic [4:0]   dReqOpm,
  input  logic [255:0] dReqDataO,
  output logic [255:0] dReqDataI,
  output logic [1:0]   dReqOK,

  output logic [19:0]  memAddr,
  output logic [4:0]   memOpm,
  output logic [255:0] memDataO,
  input  logic [255:0] memDataI,
  input  logic [1:0]   memOK,

  output logic         arbFault
);

  localparam logic [1:0] OK_READY = 2'b00;
  localparam logic [1:0] OK_OK    = 2'b01;
  localparam logic [1:0] OK_HOLD  = 2'b10;
  localparam logic [1:0] OK_FAULT = 2'b11;

  // The fault fires in the HOLD cycle that would bring the count to TMO_CYC,
  // so the owner sees FAULT on exactly the TMO_CYC-th consecutive HOLD cycle.
  localparam bit               TMO_EN   = (TMO_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t             state_q;
  port_t              rr_last_q;   // port that won the most recent collision
  logic [CNT_W-1:0]   tmo_cnt_q;
  logic               fault_q;
  logic [19:0]        mem_addr_q;
  logic [4:0]         mem_opm_q;
  logic [255:0]       mem_data_q;
  logic [255:0]       i_data_q;    // last read data shown to port I
  logic [255:0]       d_data_q;    // last read data shown to port D

  // -------------------------------------------------------------------------
  // Request decode and granted-port mux
  // -------------------------------------------------------------------------
  logic             i_act;
  logic             d_act;
  logic             g_act;
  logic [19:0]      g_addr;
  logic [4:0]       g_opm;
  logic [255:0]     g_data;
  logic             tmo_hit;
  logic [CNT_W-1:0] tmo_cnt_d;

  assign i_act = (iReqOpm[4:3] != 2'b00);
  assign d_act = (dReqOpm[4:3] != 2'b00);

  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    g_act  = 1'b0;
    g_addr = iReqAddr;
    g_opm  = iReqOpm;
    g_data = iReqDataO;
    if (state_q == GNT_I) begin
      g_act = i_act;
    end else if (state_q == GNT_D) begin
      g_act  = d_act;
      g_addr = dReqAddr;
      g_opm  = dReqOpm;
      g_data = dReqDataO;
    end
  end

  // A timeout only counts against an owner that is still active; an owner
  // dropping in the same cycle is an ordinary release.
  assign tmo_hit = TMO_EN && g_act && (memOK == OK_HOLD) &&
                   (tmo_cnt_q == TMO_LAST);

  assign tmo_cnt_d = (TMO_EN && memOK == OK_HOLD) ? tmo_cnt_q + CNT_W'(1)
                                                  : '0;

  // -------------------------------------------------------------------------
  // Response paths: the owner sees memory directly, everyone else is held
  // off (HOLD) or idle (READY) depending on whether it is asking.
  // -------------------------------------------------------------------------
  always_comb begin
    iReqOK    = i_act ? OK_HOLD : OK_READY;
    dReqOK    = d_act ? OK_HOLD : OK_READY;
    iReqDataI = i_data_q;
    dReqDataI = d_data_q;
    case (state_q)
      GNT_I: begin
        iReqOK    = tmo_hit ? OK_FAULT : memOK;
        iReqDataI = memDataI;
      end
      GNT_D: begin
        dReqOK    = tmo_hit ? OK_FAULT : memOK;
        dReqDataI = memDataI;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM and registered memory-side request
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_last_q  <= PORT_I;
      tmo_cnt_q  <= '0;
      fault_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_opm_q  <= '0;
      mem_data_q <= '0;
      i_data_q   <= '0;
      d_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_opm_q <= '0;
          tmo_cnt_q <= '0;
          if (i_act && d_act) begin
            // Collision: the port that did not win last time goes first.
            if (rr_last_q == PORT_I) begin
              state_q   <= GNT_D;
              rr_last_q <= PORT_D;
            end else begin
              state_q   <= GNT_I;
              rr_last_q <= PORT_I;
            end
          end else if (d_act) begin
            state_q <= GNT_D;
          end else if (i_act) begin
            state_q <= GNT_I;
          end
        end

        GNT_I, GNT_D: begin
          if (state_q == GNT_I) i_data_q <= memDataI;
          else                  d_data_q <= memDataI;

          if (!g_act || tmo_hit) begin
            // Release or timeout: withdraw the request and let memory
            // observe an idle cycle before anyone else is granted.
            state_q   <= DRAIN;
            mem_opm_q <= '0;
            tmo_cnt_q <= '0;
            if (tmo_hit) fault_q <= 1'b1;
          end else begin
            // The owner may retarget (writeback -> refill) without dropping;
            // the new request is simply forwarded on the next cycle.
            mem_addr_q <= g_addr;
            mem_opm_q  <= g_opm;
            mem_data_q <= g_data;
            tmo_cnt_q  <= tmo_cnt_d;
          end
        end

        DRAIN: begin
          mem_opm_q <= '0;
          tmo_cnt_q <= '0;
          // Memory keeps OK while it still sees the old request.
          if (memOK != OK_OK) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign memAddr  = mem_addr_q;
  assign memOpm   = mem_opm_q;
  assign memDataO = mem_data_q;
  assign arbFault = fault_q;

endmodule

// File: tb/tb_bsr_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_bsr_mem_arb
//
// Directed bench for bsr_mem_arb with TMO_CYC=8. The bench plays both cache
// tiles and the memory by hand, cycle by cycle. Inputs are driven 1ns after
// the rising edge; combinational outputs are checked 1ns later and
// registered outputs right after the edge.
// ---------------------------------------------------------------------------
module tb_bsr_mem_arb;

  localparam logic [1:0] READY = 2'b00;
  localparam logic [1:0] OK    = 2'b01;
  localparam logic [1:0] HOLD  = 2'b10;
  localparam logic [1:0] FAULT = 2'b11;

  localparam logic [4:0] OPM_NONE = 5'b00000;
  localparam logic [4:0] OPM_RD   = 5'b01111;
  localparam logic [4:0] OPM_WR   = 5'b10111;

  localparam logic [255:0] DA = {8{32'hA5A5_0001}};
  localparam logic [255:0] DB = {8{32'h0B0B_0002}};
  localparam logic [255:0] DC = {8{32'hC0DE_0003}};
  localparam logic [255:0] DW = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] DR = {8{32'h1234_5678}};
  localparam logic [255:0] DX = {8{32'h5A5A_7777}};

  int n_vec = 0;
  int n_bad = 0;

  logic         clock = 1'b0;
  logic         reset;
  logic [19:0]  iReqAddr;
  logic [4:0]   iReqOpm;
  logic [255:0] iReqDataO;
  logic [255:0] iReqDataI;
  logic [1:0]   iReqOK;
  logic [19:0]  dReqAddr;
  logic [4:0]   dReqOpm;
  logic [255:0] dReqDataO;
  logic [255:0] dReqDataI;
  logic [1:0]   dReqOK;
  logic [19:0]  memAddr;
  logic [4:0]   memOpm;
  logic [255:0] memDataO;
  logic [255:0] memDataI;
  logic [1:0]   memOK;
  logic         arbFault;

  always #5 clock = ~clock;

  bsr_mem_arb #(.TMO_CYC(8), .CNT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .iReqAddr  (iReqAddr),
    .iReqOpm   (iReqOpm),
    .iReqDataO (iReqDataO),
    .iReqDataI (iReqDataI),
    .iReqOK    (iReqOK),
    .dReqAddr  (dReqAddr),
    .dReqOpm   (dReqOpm),
    .dReqDataO (dReqDataO),
    .dReqDataI (dReqDataI),
    .dReqOK    (dReqOK),
    .memAddr   (memAddr),
    .memOpm    (memOpm),
    .memDataO  (memDataO),
    .memDataI  (memDataI),
    .memOK     (memOK),
    .arbFault  (arbFault)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    n_vec++; if (memOpm !== OPM_NONE) begin n_bad++; $display("FAIL rst_memOpm: got %b want %b", memOpm, OPM_NONE); end
    n_vec++; if (memAddr !== 20'h0) begin n_bad++; $display("FAIL rst_memAddr: got %h want 0", memAddr); end
    n_vec++; if (memDataO !== 256'h0) begin n_bad++; $display("FAIL rst_memDataO: got %h want 0", memDataO); end
    n_vec++; if (iReqOK !== READY) begin n_bad++; $display("FAIL rst_iReqOK: got %0d want %0d", iReqOK, READY); end
    n_vec++; if (dReqOK !== READY) begin n_bad++; $display("FAIL rst_dReqOK: got %0d want %0d", dReqOK, READY); end
    n_vec++; if (iReqDataI !== 256'h0) begin n_bad++; $display("FAIL rst_iReqDataI: got %h want 0", iReqDataI); end
    n_vec++; if (dReqDataI !== 256'h0) begin n_bad++; $display("FAIL rst_dReqDataI: got %h want 0", dReqDataI); end
    n_vec++; if (arbFault !== 1'b0) begin n_bad++; $display("FAIL rst_arbFault: got %b want 0", arbFault); end
    reset = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single_i_read();
    iReqAddr = 20'h12340; iReqOpm = OPM_RD; memOK = READY; #1;
    n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL rd_ok_idle: got %0d want %0d", iReqOK, HOLD); end
    n_vec++; if (dReqOK !== READY) begin n_bad++; $display("FAIL rd_dok_idle: got %0d want %0d", dReqOK, READY); end
    cyc(); #1;
    n_vec++; if (memOpm !== OPM_NONE) begin n_bad++; $display("FAIL rd_memOpm_gnt: got %b want %b", memOpm, OPM_NONE); end
    cyc();
    n_vec++; if (memAddr !== 20'h12340) begin n_bad++; $display("FAIL rd_memAddr: got %h want 12340", memAddr); end
    n_vec++; if (memOpm !== OPM_RD) begin n_bad++; $display("FAIL rd_memOpm: got %b want %b", memOpm, OPM_RD); end
    memOK = HOLD; #1;
    n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL rd_hold0: got %0d want %0d", iReqOK, HOLD); end
    for (int h = 1; h < 3; h++) begin
      cyc(); memOK = HOLD; #1;
      n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL rd_hold%0d: got %0d want %0d", h, iReqOK, HOLD); end
      n_vec++; if (dReqOK !== READY) begin n_bad++; $display("FAIL rd_dok%0d: got %0d want %0d", h, dReqOK, READY); end
    end
    cyc(); memOK = OK; memDataI = DA; #1;
    n_vec++; if (iReqOK !== OK) begin n_bad++; $display("FAIL rd_ok: got %0d want %0d", iReqOK, OK); end
    n_vec++; if (iReqDataI !== DA) begin n_bad++; $display("FAIL rd_data: got %h want %h", iReqDataI, DA); end
    n_vec++; if (dReqOK !== READY) begin n_bad++; $display("FAIL rd_dok_done: got %0d want %0d", dReqOK, READY); end
    n_vec++; if (dReqDataI !== 256'h0) begin n_bad++; $display("FAIL rd_ddata: got %h want 0", dReqDataI); end
    cyc(); iReqOpm = OPM_NONE; #1;
    cyc();
    n_vec++; if (memOpm !== OPM_NONE) begin n_bad++; $display("FAIL rd_drain_opm: got %b want %b", memOpm, OPM_NONE); end
    memOK = READY; memDataI = '0; #1;
    n_vec++; if (iReqOK !== READY) begin n_bad++; $display("FAIL rd_drain_ok: got %0d want %0d", iReqOK, READY); end
    n_vec++; if (iReqDataI !== DA) begin n_bad++; $display("FAIL rd_data_held: got %h want %h", iReqDataI, DA); end
    cyc();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_collision();
    iReqAddr = 20'h00100; dReqAddr = 20'h00200; iReqOpm = OPM_RD; dReqOpm = OPM_RD; memOK = READY; #1;
    n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL col_iok_idle: got %0d want %0d", iReqOK, HOLD); end
    n_vec++; if (dReqOK !== HOLD) begin n_bad++; $display("FAIL col_dok_idle: got %0d want %0d", dReqOK, HOLD); end
    cyc(); #1;
    n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL col_iok_blocked: got %0d want %0d", iReqOK, HOLD); end
    cyc();
    n_vec++; if (memAddr !== 20'h00200) begin n_bad++; $display("FAIL col_first_d: got %h want 00200", memAddr); end
    memOK = OK; memDataI = DB; #1;
    n_vec++; if (dReqOK !== OK) begin n_bad++; $display("FAIL col_dok: got %0d want %0d", dReqOK, OK); end
    n_vec++; if (dReqDataI !== DB) begin n_bad++; $display("FAIL col_ddata: got %h want %h", dReqDataI, DB); end
    n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL col_iok_wait: got %0d want %0d", iReqOK, HOLD); end
    cyc(); dReqOpm = OPM_NONE; #1;
    cyc(); memOK = READY; #1;
    n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL col_iok_drain: got %0d want %0d", iReqOK, HOLD); end
    n_vec++; if (memOpm !== OPM_NONE) begin n_bad++; $display("FAIL col_drain_opm: got %b want %b", memOpm, OPM_NONE); end
    cyc(); #1;
    cyc(); #1;
    cyc();
    n_vec++; if (memAddr !== 20'h00100) begin n_bad++; $display("FAIL col_then_i: got %h want 00100", memAddr); end
    memOK = OK; memDataI = DC; #1;
    n_vec++; if (iReqOK !== OK) begin n_bad++; $display("FAIL col_iok: got %0d want %0d", iReqOK, OK); end
    n_vec++; if (iReqDataI !== DC) begin n_bad++; $display("FAIL col_idata: got %h want %h", iReqDataI, DC); end
    n_vec++; if (dReqDataI !== DB) begin n_bad++; $display("FAIL col_ddata_held: got %h want %h", dReqDataI, DB); end
    cyc(); iReqOpm = OPM_NONE; #1;
    cyc(); memOK = READY; #1;
    cyc();
    // Second collision: I won nothing last time, so I goes first now.
    iReqAddr = 20'h00300; dReqAddr = 20'h00400; iReqOpm = OPM_RD; dReqOpm = OPM_RD; #1;
    cyc(); #1;
    n_vec++; if (dReqOK !== HOLD) begin n_bad++; $display("FAIL col2_dok_blocked: got %0d want %0d", dReqOK, HOLD); end
    cyc();
    n_vec++; if (memAddr !== 20'h00300) begin n_bad++; $display("FAIL col2_first_i: got %h want 00300", memAddr); end
    memOK = OK; #1;
    n_vec++; if (iReqOK !== OK) begin n_bad++; $display("FAIL col2_iok: got %0d want %0d", iReqOK, OK); end
    cyc(); iReqOpm = OPM_NONE; #1;
    cyc(); memOK = READY; #1;
    cyc(); #1;
    cyc(); #1;
    cyc();
    n_vec++; if (memAddr !== 20'h00400) begin n_bad++; $display("FAIL col2_then_d: got %h want 00400", memAddr); end
    memOK = OK; #1;
    n_vec++; if (dReqOK !== OK) begin n_bad++; $display("FAIL col2_dok: got %0d want %0d", dReqOK, OK); end
    cyc(); dReqOpm = OPM_NONE; #1;
    cyc(); memOK = READY; #1;
    cyc();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wb_refill();
    dReqAddr = 20'h0AAAA; dReqDataO = DW; dReqOpm = OPM_WR; memOK = READY; #1;
    n_vec++; if (dReqOK !== HOLD) begin n_bad++; $display("FAIL wb_dok_idle: got %0d want %0d", dReqOK, HOLD); end
    cyc(); iReqAddr = 20'h05555; iReqOpm = OPM_RD; #1;
    n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL wb_iok0: got %0d want %0d", iReqOK, HOLD); end
    cyc();
    n_vec++; if (memOpm !== OPM_WR) begin n_bad++; $display("FAIL wb_memOpm: got %b want %b", memOpm, OPM_WR); end
    n_vec++; if (memAddr !== 20'h0AAAA) begin n_bad++; $display("FAIL wb_memAddr: got %h want 0aaaa", memAddr); end
    n_vec++; if (memDataO !== DW) begin n_bad++; $display("FAIL wb_memDataO: got %h want %h", memDataO, DW); end
    memOK = HOLD; #1;
    n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL wb_iok1: got %0d want %0d", iReqOK, HOLD); end
    cyc(); memOK = OK; #1;
    n_vec++; if (dReqOK !== OK) begin n_bad++; $display("FAIL wb_dok: got %0d want %0d", dReqOK, OK); end
    cyc(); dReqOpm = OPM_RD; dReqAddr = 20'h0BBBB; #1;
    n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL wb_iok2: got %0d want %0d", iReqOK, HOLD); end
    cyc();
    n_vec++; if (memOpm !== OPM_RD) begin n_bad++; $display("FAIL rf_memOpm: got %b want %b", memOpm, OPM_RD); end
    n_vec++; if (memAddr !== 20'h0BBBB) begin n_bad++; $display("FAIL rf_memAddr: got %h want 0bbbb", memAddr); end
    memOK = HOLD; #1;
    n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL rf_iok: got %0d want %0d", iReqOK, HOLD); end
    cyc(); memOK = OK; memDataI = DR; #1;
    n_vec++; if (dReqOK !== OK) begin n_bad++; $display("FAIL rf_dok: got %0d want %0d", dReqOK, OK); end
    n_vec++; if (dReqDataI !== DR) begin n_bad++; $display("FAIL rf_ddata: got %h want %h", dReqDataI, DR); end
    cyc(); dReqOpm = OPM_NONE; #1;
    cyc();
    n_vec++; if (memOpm !== OPM_NONE) begin n_bad++; $display("FAIL rf_drain_opm: got %b want %b", memOpm, OPM_NONE); end
    memOK = READY; #1;
    n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL rf_iok_drain: got %0d want %0d", iReqOK, HOLD); end
    n_vec++; if (dReqDataI !== DR) begin n_bad++; $display("FAIL rf_ddata_held: got %h want %h", dReqDataI, DR); end
    cyc(); #1;
    cyc(); #1;
    cyc();
    n_vec++; if (memAddr !== 20'h05555) begin n_bad++; $display("FAIL rf_then_i: got %h want 05555", memAddr); end
    memOK = OK; #1;
    cyc(); iReqOpm = OPM_NONE; #1;
    cyc(); memOK = READY; #1;
    cyc();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_timeout();
    dReqAddr = 20'h0DEAD; dReqOpm = OPM_RD; memOK = HOLD; #1;
    n_vec++; if (dReqOK !== HOLD) begin n_bad++; $display("FAIL tmo_dok_idle: got %0d want %0d", dReqOK, HOLD); end
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 3) begin iReqAddr = 20'h0BEEF; iReqOpm = OPM_RD; end
      #1;
      if (c < 8) begin
        n_vec++; if (dReqOK !== HOLD) begin n_bad++; $display("FAIL tmo_hold%0d: got %0d want %0d", c, dReqOK, HOLD); end
      end else begin
        n_vec++; if (dReqOK !== FAULT) begin n_bad++; $display("FAIL tmo_fault: got %0d want %0d", dReqOK, FAULT); end
        n_vec++; if (memOpm !== OPM_RD) begin n_bad++; $display("FAIL tmo_memOpm_live: got %b want %b", memOpm, OPM_RD); end
        n_vec++; if (arbFault !== 1'b0) begin n_bad++; $display("FAIL tmo_flag_early: got %b want 0", arbFault); end
        n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL tmo_iok_wait: got %0d want %0d", iReqOK, HOLD); end
      end
    end
    cyc();
    n_vec++; if (memOpm !== OPM_NONE) begin n_bad++; $display("FAIL tmo_memOpm_drop: got %b want %b", memOpm, OPM_NONE); end
    n_vec++; if (arbFault !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b want 1", arbFault); end
    dReqOpm = OPM_NONE; memOK = READY; #1;
    n_vec++; if (dReqOK !== READY) begin n_bad++; $display("FAIL tmo_fault_once: got %0d want %0d", dReqOK, READY); end
    n_vec++; if (iReqOK !== HOLD) begin n_bad++; $display("FAIL tmo_iok_drain: got %0d want %0d", iReqOK, HOLD); end
    cyc(); #1;
    cyc(); #1;
    cyc();
    n_vec++; if (memAddr !== 20'h0BEEF) begin n_bad++; $display("FAIL tmo_then_i: got %h want 0beef", memAddr); end
    memOK = OK; #1;
    n_vec++; if (iReqOK !== OK) begin n_bad++; $display("FAIL tmo_iok: got %0d want %0d", iReqOK, OK); end
    cyc(); iReqOpm = OPM_NONE; #1;
    cyc(); memOK = READY; #1;
    cyc();
    n_vec++; if (arbFault !== 1'b1) begin n_bad++; $display("FAIL tmo_flag_sticky: got %b want 1", arbFault); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    iReqAddr = 20'h00777; iReqOpm = OPM_RD; memOK = READY; #1;
    cyc(); #1;
    cyc();
    n_vec++; if (memOpm !== OPM_RD) begin n_bad++; $display("FAIL rm_memOpm_live: got %b want %b", memOpm, OPM_RD); end
    memOK = HOLD; memDataI = DX; #1;
    n_vec++; if (iReqDataI !== DX) begin n_bad++; $display("FAIL rm_idata_pass: got %h want %h", iReqDataI, DX); end
    reset = 1'b1; iReqOpm = OPM_NONE;
    cyc();
    n_vec++; if (memOpm !== OPM_NONE) begin n_bad++; $display("FAIL rm_memOpm: got %b want %b", memOpm, OPM_NONE); end
    n_vec++; if (memAddr !== 20'h0) begin n_bad++; $display("FAIL rm_memAddr: got %h want 0", memAddr); end
    n_vec++; if (arbFault !== 1'b0) begin n_bad++; $display("FAIL rm_arbFault: got %b want 0", arbFault); end
    reset = 1'b0; memOK = READY; memDataI = '0; #1;
    n_vec++; if (iReqOK !== READY) begin n_bad++; $display("FAIL rm_iok: got %0d want %0d", iReqOK, READY); end
    n_vec++; if (iReqDataI !== 256'h0) begin n_bad++; $display("FAIL rm_idata: got %h want 0", iReqDataI); end
    cyc();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_release_at_timeout();
    dReqAddr = 20'h0CAFE; dReqOpm = OPM_RD; memOK = HOLD; #1;
    for (int c = 1; c < 8; c++) begin
      cyc(); #1;
    end
    cyc(); dReqOpm = OPM_NONE; #1;
    n_vec++; if (dReqOK !== HOLD) begin n_bad++; $display("FAIL rel_no_fault: got %0d want %0d", dReqOK, HOLD); end
    cyc();
    n_vec++; if (memOpm !== OPM_NONE) begin n_bad++; $display("FAIL rel_memOpm: got %b want %b", memOpm, OPM_NONE); end
    n_vec++; if (arbFault !== 1'b0) begin n_bad++; $display("FAIL rel_arbFault: got %b want 0", arbFault); end
    memOK = READY; #1;
    cyc();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_idle();
    iReqOpm = OPM_NONE; dReqOpm = OPM_NONE; memOK = READY;
    for (int c = 0; c < 20; c++) begin
      cyc(); #1;
      n_vec++; if (memOpm !== OPM_NONE) begin n_bad++; $display("FAIL idle_memOpm%0d: got %b want %b", c, memOpm, OPM_NONE); end
      n_vec++; if (iReqOK !== READY) begin n_bad++; $display("FAIL idle_iok%0d: got %0d want %0d", c, iReqOK, READY); end
      n_vec++; if (dReqOK !== READY) begin n_bad++; $display("FAIL idle_dok%0d: got %0d want %0d", c, dReqOK, READY); end
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    iReqAddr  = '0; iReqOpm = OPM_NONE; iReqDataO = '0;
    dReqAddr  = '0; dReqOpm = OPM_NONE; dReqDataO = '0;
    memDataI  = '0; memOK   = READY;

    test_reset();
    test_single_i_read();
    test_collision();
    test_wb_refill();
    test_timeout();
    test_reset_mid();
    test_release_at_timeout();
    test_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
